// File: rtl/ls_pkg.sv
// Shared opcode, state and sizing helpers for the ROB load/store path.
// Imported by mem_access_unit and load_extend.
package ls_pkg;

    localparam logic [31:0] IO_BASE_DEFAULT = 32'h0003_0000;

    localparam logic [5:0] OP_LB  = 6'd1;
    localparam logic [5:0] OP_LH  = 6'd2;
    localparam logic [5:0] OP_LW  = 6'd3;
    localparam logic [5:0] OP_LBU = 6'd4;
    localparam logic [5:0] OP_LHU = 6'd5;
    localparam logic [5:0] OP_SB  = 6'd6;
    localparam logic [5:0] OP_SH  = 6'd7;
    localparam logic [5:0] OP_SW  = 6'd8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        TAIL = 2'd2
    } state_t;

    function automatic logic [2:0] byte_count(
        input logic [5:0] op
    );
        case (op)
            OP_LH, OP_LHU, OP_SH: byte_count = 3'd2;
            OP_LW, OP_SW:         byte_count = 3'd4;
            default:              byte_count = 3'd1;
        endcase
    endfunction

    function automatic logic is_store(
        input logic [5:0] op
    );
        is_store = (op == OP_SB) || (op == OP_SH) ||
                   (op == OP_SW);
    endfunction

endpackage

// File: rtl/load_extend.sv
// Load result formatter: sign/zero extension of up to 4 LE bytes.
// Ports: opcode, b0..b3 (b0 = lowest address) in; data (32b) out.
module load_extend
    import ls_pkg::*;
(
    input  logic [5:0]  opcode,
    input  logic [7:0]  b0,
    input  logic [7:0]  b1,
    input  logic [7:0]  b2,
    input  logic [7:0]  b3,
    output logic [31:0] data
);

    always_comb begin
        data = {b3, b2, b1, b0};
        case (opcode)
            OP_LB:   data = {{24{b0[7]}}, b0};
            OP_LH:   data = {{16{b1[7]}}, b1, b0};
            OP_LBU:  data = {24'd0, b0};
            OP_LHU:  data = {16'd0, b1, b0};
            default: data = {b3, b2, b1, b0};
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// ROB commit responder: runs one load/store as 1/2/4 byte bus accesses.
// Ports: clk, rst (async low), rdy, lsb_* request/completion, busy,
// mem_* byte bus with arbiter grant, io_buffer_full.
// Optional MAU_PERF_CNT_EN adds perf_loads/perf_stores/perf_stall_cycles.
module mem_access_unit
    import ls_pkg::*;
#(
    parameter logic [31:0] IO_BASE = IO_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        lsb_enable,
    input  logic [5:0]  lsb_rob_index,
    input  logic [5:0]  lsb_opcode,
    input  logic [31:0] lsb_ls_addr,
    input  logic [31:0] lsb_s_val,
    output logic        lsb_ls_enable,
    output logic [5:0]  lsb_rob_index_out,
    output logic [31:0] lsb_l_data,
    output logic        busy,
    output logic        mem_req,
    input  logic        mem_grant,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    output logic [7:0]  mem_dout,
    input  logic [7:0]  mem_din,
    input  logic        io_buffer_full
`ifdef MAU_PERF_CNT_EN
    ,
    output logic [31:0] perf_loads,
    output logic [31:0] perf_stores,
    output logic [31:0] perf_stall_cycles
`endif
);

    state_t          state;
    state_t          state_nxt;
    logic [5:0]      op_q;
    logic [5:0]      idx_q;
    logic [31:0]     addr_q;
    logic [31:0]     sval_q;
    logic [1:0]      k;
    logic [3:0][7:0] slot;
    logic            pend_v;
    logic [1:0]      pend_j;
    logic [3:0][7:0] bytes;
    logic [31:0]     ext;
    logic            st;
    logic            last;
    logic            issue;
    logic            accept;
    logic            done_ld;

    assign st     = is_store(op_q);
    assign last   = ({1'b0, k} == byte_count(op_q) - 3'd1);
    assign accept = (state == IDLE) && rdy && lsb_enable;
    assign issue  = (state == XFER) && mem_req && mem_grant;
    assign done_ld = (state == TAIL) && rdy;
    assign busy   = (state != IDLE);

    always_comb begin
        mem_req  = 1'b0;
        mem_wr   = 1'b0;
        mem_a    = 32'd0;
        mem_dout = 8'd0;
        if (state == XFER) begin
            // Only I/O stores back-pressure; loads never wait on it.
            mem_req  = rdy && !(st && (addr_q >= IO_BASE) &&
                                io_buffer_full);
            mem_a    = addr_q + {30'd0, k};
            mem_wr   = mem_req && st;
            mem_dout = sval_q[{k, 3'b000} +: 8];
        end
    end

    // The last read byte arrives on mem_din in TAIL, before it is
    // written to its slot, so bypass it into the extender.
    always_comb begin
        bytes = slot;
        if (pend_v) bytes[pend_j] = mem_din;
    end

    load_extend u_ext (
        .opcode (op_q),
        .b0     (bytes[0]),
        .b1     (bytes[1]),
        .b2     (bytes[2]),
        .b3     (bytes[3]),
        .data   (ext)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept) state_nxt = XFER;
            XFER: if (issue && last)
                      state_nxt = st ? IDLE : TAIL;
            TAIL: if (rdy) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q              <= 6'd0;
            idx_q             <= 6'd0;
            addr_q            <= 32'd0;
            sval_q            <= 32'd0;
            k                 <= 2'd0;
            slot              <= '0;
            pend_v            <= 1'b0;
            pend_j            <= 2'd0;
            lsb_ls_enable     <= 1'b0;
            lsb_rob_index_out <= 6'd0;
            lsb_l_data        <= 32'd0;
        end else begin
            lsb_ls_enable <= 1'b0;
            // Read capture ignores rdy/grant: the byte is on
            // the bus exactly one cycle after its grant.
            if (pend_v) slot[pend_j] <= mem_din;
            pend_v <= issue && !st;
            pend_j <= k;
            if (accept) begin
                op_q   <= lsb_opcode;
                idx_q  <= lsb_rob_index;
                addr_q <= lsb_ls_addr;
                sval_q <= lsb_s_val;
                k      <= 2'd0;
            end
            if (issue) begin
                k <= k + 2'd1;
                if (last && st) begin
                    lsb_ls_enable     <= 1'b1;
                    lsb_l_data        <= 32'd0;
                    lsb_rob_index_out <= idx_q;
                end
            end
            if (done_ld) begin
                lsb_ls_enable     <= 1'b1;
                lsb_l_data        <= ext;
                lsb_rob_index_out <= idx_q;
            end
        end
    end

`ifdef MAU_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_loads        <= 32'd0;
            perf_stores       <= 32'd0;
            perf_stall_cycles <= 32'd0;
        end else begin
            if (done_ld) perf_loads <= perf_loads + 32'd1;
            if (issue && last && st)
                perf_stores <= perf_stores + 32'd1;
            if ((state == XFER) && !issue)
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: vector table plus
// hand sequences for stalls, back-to-back and mid-transfer reset.
module tb_mem_access_unit;
    import ls_pkg::*;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        lsb_enable;
    logic [5:0]  lsb_rob_index;
    logic [5:0]  lsb_opcode;
    logic [31:0] lsb_ls_addr;
    logic [31:0] lsb_s_val;
    logic        lsb_ls_enable;
    logic [5:0]  lsb_rob_index_out;
    logic [31:0] lsb_l_data;
    logic        busy;
    logic        mem_req;
    logic        mem_grant;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
`ifdef MAU_PERF_CNT_EN
    logic [31:0] perf_loads;
    logic [31:0] perf_stores;
    logic [31:0] perf_stall_cycles;
`endif

    mem_access_unit dut (
        .clk               (clk),
        .rst               (rst),
        .rdy               (rdy),
        .lsb_enable        (lsb_enable),
        .lsb_rob_index     (lsb_rob_index),
        .lsb_opcode        (lsb_opcode),
        .lsb_ls_addr       (lsb_ls_addr),
        .lsb_s_val         (lsb_s_val),
        .lsb_ls_enable     (lsb_ls_enable),
        .lsb_rob_index_out (lsb_rob_index_out),
        .lsb_l_data        (lsb_l_data),
        .busy              (busy),
        .mem_req           (mem_req),
        .mem_grant         (mem_grant),
        .mem_a             (mem_a),
        .mem_wr            (mem_wr),
        .mem_dout          (mem_dout),
        .mem_din           (mem_din),
        .io_buffer_full    (io_buffer_full)
`ifdef MAU_PERF_CNT_EN
        ,
        .perf_loads        (perf_loads),
        .perf_stores       (perf_stores),
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    typedef struct {
        logic [5:0]  idx;
        logic [31:0] data;
        int          due;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [7:0]  d;
    } wr_t;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  idx;
        logic [31:0] addr;
        logic [31:0] sval;
        logic [31:0] mdat;
        logic        io;
        logic [31:0] exp;
        int          n;
    } vec_t;

    exp_t sb[$];
    wr_t  wlog[$];
    logic [7:0] mem [logic [31:0]];
    vec_t tv [13];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic        rd_pend = 1'b0;
    logic [31:0] rd_addr = 32'd0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp,
                     $time);
        end
    endtask

    function automatic logic [7:0] rdmem(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 8'h00;
    endfunction

    // Byte-wide memory: read data valid one cycle after the grant.
    always @(posedge clk) begin
        rd_pend <= mem_req && mem_grant && !mem_wr;
        rd_addr <= mem_a;
        if (mem_req && mem_grant && mem_wr) begin
            if (!rdy) chk("wr_while_frozen", 32'd1, 32'd0);
            wlog.push_back('{mem_a, mem_dout});
        end
    end

    always @(negedge clk) mem_din = rd_pend ? rdmem(rd_addr) : 8'hEE;

    always @(negedge clk) begin
        if (rst && lsb_ls_enable) begin
            if (sb.size() == 0) begin
                chk("stray_pulse", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("idx", {26'd0, lsb_rob_index_out}, {26'd0, e.idx});
                chk("ldata", lsb_l_data, e.data);
                chk("pulse_cyc", cyc, e.due);
            end
        end
    end

    task automatic drive(input logic [5:0] op, input logic [5:0] idx,
                         input logic [31:0] a, input logic [31:0] v,
                         input logic [31:0] exp, input int lat,
                         input bit push);
        lsb_enable    = 1'b1;
        lsb_opcode    = op;
        lsb_rob_index = idx;
        lsb_ls_addr   = a;
        lsb_s_val     = v;
        if (push) sb.push_back('{idx, exp, cyc + lat});
        #1;
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40; i++) begin
            if (sb.size() == 0) break;
            step();
        end
        if (sb.size() != 0) begin
            chk("timeout", sb.size(), 32'd0);
            sb.delete();
        end
    endtask

    task automatic chk_writes(input string nm, input logic [31:0] a,
                              input logic [31:0] v, input int n);
        chk({nm, "_wcnt"}, wlog.size(), n);
        for (int j = 0; j < n && j < wlog.size(); j++) begin
            chk({nm, "_wa"}, wlog[j].a, a + j);
            chk({nm, "_wd"}, {24'd0, wlog[j].d}, {24'd0, v[8*j +: 8]});
        end
        wlog.delete();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bit s;
        rst = 1'b0; rdy = 1'b1; lsb_enable = 1'b0;
        lsb_rob_index = 6'd0; lsb_opcode = 6'd0;
        lsb_ls_addr = 32'd0; lsb_s_val = 32'd0;
        mem_grant = 1'b1; io_buffer_full = 1'b0;

        tv[0]  = '{OP_LW,  6'd1,  32'h100, 0, 32'h12345678, 0, 32'h12345678, 4};
        tv[1]  = '{OP_LB,  6'd2,  32'h200, 0, 32'h80, 0, 32'hFFFFFF80, 1};
        tv[2]  = '{OP_LBU, 6'd3,  32'h200, 0, 32'h80, 0, 32'h00000080, 1};
        tv[3]  = '{OP_LH,  6'd4,  32'h201, 0, 32'hFF80, 0, 32'hFFFFFF80, 2};
        tv[4]  = '{OP_LHU, 6'd5,  32'h201, 0, 32'hFF80, 0, 32'h0000FF80, 2};
        tv[5]  = '{OP_LW,  6'd6,  32'hFFFFFFFE, 0, 32'h44332211, 0,
                   32'h44332211, 4};
        tv[6]  = '{OP_LH,  6'd7,  32'h500, 0, 32'h7234, 0, 32'h00007234, 2};
        tv[7]  = '{OP_LB,  6'd8,  32'h501, 0, 32'h7F, 0, 32'h0000007F, 1};
        tv[8]  = '{OP_SW,  6'd9,  32'h600, 32'hCAFEF00D, 0, 0, 0, 4};
        tv[9]  = '{OP_SH,  6'd10, 32'h700, 32'h12345678, 0, 0, 0, 2};
        tv[10] = '{OP_SB,  6'd11, 32'h2FFFF, 32'h3C, 0, 1, 0, 1};
        tv[11] = '{OP_LBU, 6'd12, 32'h30004, 0, 32'h9C, 1, 32'h9C, 1};
        tv[12] = '{OP_SB,  6'd63, 32'h30000, 32'hA5, 0, 0, 0, 1};

        repeat (3) step();
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_req", {31'd0, mem_req}, 0);
        chk("rst_a", mem_a, 0);
        chk("rst_pulse", {31'd0, lsb_ls_enable}, 0);
        chk("rst_ldata", lsb_l_data, 0);
        chk("rst_idx", {26'd0, lsb_rob_index_out}, 0);
        rst = 1'b1;
        step();

        foreach (tv[i]) begin
            vec_t v;
            v = tv[i];
            s = (v.op == OP_SB) || (v.op == OP_SH) || (v.op == OP_SW);
            for (int j = 0; j < v.n; j++)
                mem[v.addr + j] = v.mdat[8*j +: 8];
            io_buffer_full = v.io;
            drive(v.op, v.idx, v.addr, v.sval, v.exp,
                  s ? v.n + 1 : v.n + 2, 1);
            step();
            lsb_enable = 1'b0;
            chk("busy", {31'd0, busy}, 1);
            for (int m = 0; m < v.n; m++) begin
                chk("req", {31'd0, mem_req}, 1);
                chk("a", mem_a, v.addr + m);
                chk("wr", {31'd0, mem_wr}, {31'd0, s});
                if (s) chk("dout", {24'd0, mem_dout},
                           {24'd0, v.sval[8*m +: 8]});
                step();
            end
            wait_done();
            io_buffer_full = 1'b0;
            chk("idle", {31'd0, busy}, 0);
            chk_writes("vec", v.addr, v.sval, s ? v.n : 0);
            step();
        end

        // SW with grant low in cycle 2 and rdy low in cycle 4.
        drive(OP_SW, 6'd14, 32'h300, 32'hA1B2C3D4, 0, 7, 1);
        step(); lsb_enable = 1'b0;
        chk("sw_a1", mem_a, 32'h300);
        chk("sw_d1", {24'd0, mem_dout}, 32'hD4);
        step(); mem_grant = 1'b0; #1;
        chk("sw_a2", mem_a, 32'h301);
        step(); mem_grant = 1'b1; #1;
        chk("sw_a3", mem_a, 32'h301);
        chk("sw_d3", {24'd0, mem_dout}, 32'hC3);
        step(); rdy = 1'b0; #1;
        chk("sw_req4", {31'd0, mem_req}, 0);
        chk("sw_wr4", {31'd0, mem_wr}, 0);
        chk("sw_a4", mem_a, 32'h302);
        step(); rdy = 1'b1; #1;
        chk("sw_d5", {24'd0, mem_dout}, 32'hB2);
        step();
        chk("sw_d6", {24'd0, mem_dout}, 32'hA1);
        wait_done();
        chk_writes("sw", 32'h300, 32'hA1B2C3D4, 4);
        step();

        // I/O store held off by a full buffer for 3 cycles.
        io_buffer_full = 1'b1;
        drive(OP_SB, 6'd15, 32'h30000, 32'h77, 0, 5, 1);
        step(); lsb_enable = 1'b0;
        for (int m = 1; m <= 3; m++) begin
            chk("io_req_off", {31'd0, mem_req}, 0);
            step();
        end
        io_buffer_full = 1'b0; #1;
        chk("io_req_on", {31'd0, mem_req}, 1);
        chk("io_wr_on", {31'd0, mem_wr}, 1);
        wait_done();
        chk_writes("io", 32'h30000, 32'h77, 1);
        step();

        // Request during XFER is ignored; one in the pulse cycle is taken.
        drive(OP_SB, 6'd20, 32'h800, 32'h5A, 0, 2, 1);
        step();
        drive(OP_SW, 6'd21, 32'h900, 32'h11111111, 0, 0, 0);
        step();
        chk("b2b_pulse", {31'd0, lsb_ls_enable}, 1);
        drive(OP_LB, 6'd22, 32'h200, 0, 32'hFFFFFF80, 3, 1);
        step(); lsb_enable = 1'b0;
        wait_done();
        chk_writes("b2b", 32'h800, 32'h5A, 1);
        step();

        // Reset in the middle of an LW, then a clean SH.
        drive(OP_LW, 6'd5, 32'h100, 0, 0, 0, 0);
        step(); lsb_enable = 1'b0;
        step(); step();
        rst = 1'b0; #1;
        chk("mr_busy", {31'd0, busy}, 0);
        chk("mr_req", {31'd0, mem_req}, 0);
        chk("mr_wr", {31'd0, mem_wr}, 0);
        chk("mr_a", mem_a, 0);
        chk("mr_dout", {24'd0, mem_dout}, 0);
        chk("mr_pulse", {31'd0, lsb_ls_enable}, 0);
        chk("mr_ldata", lsb_l_data, 0);
        chk("mr_idx", {26'd0, lsb_rob_index_out}, 0);
        step(); rst = 1'b1;
        step();
        drive(OP_SH, 6'd9, 32'h400, 32'h0000BEEF, 0, 3, 1);
        step(); lsb_enable = 1'b0;
        wait_done();
        repeat (4) step();
        chk_writes("sh", 32'h400, 32'h0000BEEF, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
